// File: rtl/wfi_sleep_seq_if.sv
// wfi_sleep_seq_if: CPU/pad-freeze/clock-gate signal bundle for the WFI sleep sequencer.
interface wfi_sleep_seq_if;
  logic       wfi_req;
  logic       irq_pending;
  logic       led_wr;
  logic       wfi;
  logic       core_clk_en;
  logic       wfi_ack;
  logic       timeout_wake;
  logic [2:0] state;
  modport master (
    output wfi_req, irq_pending, led_wr,
    input  wfi, core_clk_en, wfi_ack, timeout_wake, state
  );
  modport slave (
    input  wfi_req, irq_pending, led_wr,
    output wfi, core_clk_en, wfi_ack, timeout_wake, state
  );
endinterface

// File: rtl/wfi_sleep_seq.sv
// wfi_sleep_seq: drains LED writes, gates LED pads then the core clock on WFI, reverses on irq.
// Optional sleep watchdog (TIMEOUT_CYCLES) enabled by defining WFI_SEQ_TIMEOUT_EN.
module wfi_sleep_seq #(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned WAKE_CYCLES = 8
`ifdef WFI_SEQ_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 16'hFFFF
`endif
) (
  input logic            clk,
  input logic            rst_n,
  wfi_sleep_seq_if.slave bus
);
  typedef enum logic [2:0] {
    RUN   = 3'd0,
    DRAIN = 3'd1,
    GATE  = 3'd2,
    SLEEP = 3'd3,
    WAKE  = 3'd4
  } state_t;
  localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);
  localparam logic [7:0] WAKE_LOAD  = 8'(WAKE_CYCLES - 1);
  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       r_wfi, r_clk_en, r_ack, r_tw;
  logic       w_ack_nxt, w_tw_nxt, w_timeout;
`ifdef WFI_SEQ_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_slp;
  // Zero outside SLEEP, so it is already cleared on the SLEEP entry edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_slp <= '0;
    else        r_slp <= (r_state == SLEEP) ? r_slp + 16'd1 : '0;
  assign w_timeout = (r_state == SLEEP) && (r_slp == TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state  <= RUN;
      r_cnt    <= '0;
      r_wfi    <= 1'b0;
      r_clk_en <= 1'b1;
      r_ack    <= 1'b0;
      r_tw     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_wfi    <= w_state_nxt inside {GATE, SLEEP, WAKE};
      r_clk_en <= w_state_nxt != SLEEP;
      r_ack    <= w_ack_nxt;
      r_tw     <= w_tw_nxt;
    end
  always_comb begin
    w_state_nxt = RUN;
    w_cnt_nxt   = r_cnt;
    w_ack_nxt   = 1'b0;
    w_tw_nxt    = 1'b0;
    case (r_state)
      RUN:
        if (bus.wfi_req && bus.irq_pending) w_ack_nxt = 1'b1;
        else if (bus.wfi_req) begin
          w_state_nxt = DRAIN;
          w_cnt_nxt   = DRAIN_LOAD;
        end
      DRAIN:
        if (bus.irq_pending) w_ack_nxt = 1'b1;
        else if (!bus.wfi_req) w_state_nxt = RUN;
        else if (bus.led_wr) begin
          w_state_nxt = DRAIN;
          w_cnt_nxt   = DRAIN_LOAD;
        end else if (r_cnt == 8'd0) w_state_nxt = GATE;
        else begin
          w_state_nxt = DRAIN;
          w_cnt_nxt   = r_cnt - 8'd1;
        end
      GATE: begin
        w_state_nxt = bus.irq_pending ? WAKE : SLEEP;
        w_cnt_nxt   = bus.irq_pending ? WAKE_LOAD : r_cnt;
      end
      SLEEP: begin
        w_state_nxt = (bus.irq_pending || w_timeout) ? WAKE : SLEEP;
        w_cnt_nxt   = (bus.irq_pending || w_timeout) ? WAKE_LOAD : r_cnt;
        w_tw_nxt    = w_timeout && !bus.irq_pending;
      end
      WAKE:
        if (r_cnt == 8'd0) w_ack_nxt = 1'b1;
        else begin
          w_state_nxt = WAKE;
          w_cnt_nxt   = r_cnt - 8'd1;
        end
      default: w_state_nxt = RUN;
    endcase
  end
  assign bus.state        = r_state;
  assign bus.wfi          = r_wfi;
  assign bus.core_clk_en  = r_clk_en;
  assign bus.wfi_ack      = r_ack;
  assign bus.timeout_wake = r_tw;
endmodule

// File: tb/tb_wfi_sleep_seq.sv
// tb_wfi_sleep_seq: directed checks of sleep entry, drain, wake, abort, reset and watchdog.
module tb_wfi_sleep_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  wfi_sleep_seq_if bus ();
  wfi_sleep_seq #(
    .DRAIN_CYCLES(4),
    .WAKE_CYCLES(8)
`ifdef WFI_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic enter_sleep();
    bus.wfi_req = 1'b1;
    repeat (6) tick();
  endtask
  task automatic wake_up(input string name);
    bus.irq_pending = 1'b1;
    tick();
    bus.irq_pending = 1'b0;
    for (int i = 0; i < 40 && bus.wfi_ack !== 1'b1; i++) tick();
    checks++;
    if (bus.wfi_ack !== 1'b1) begin
      errors++;
      $display("FAIL %s wake ack: got %b want 1", name, bus.wfi_ack);
    end
    bus.wfi_req = 1'b0;
    tick();
  endtask
  task automatic test_reset();
    bus.wfi_req = 1'b0; bus.irq_pending = 1'b0; bus.led_wr = 1'b0;
    rst_n = 1'b0;
    tick();
    checks++;
    if ({bus.state, bus.wfi, bus.core_clk_en, bus.wfi_ack, bus.timeout_wake} !== 7'b000_0_1_0_0) begin
      errors++;
      $display("FAIL reset: got st=%0d wfi=%b en=%b ack=%b tw=%b want 0 0 1 0 0",
               bus.state, bus.wfi, bus.core_clk_en, bus.wfi_ack, bus.timeout_wake);
    end
    rst_n = 1'b1;
    tick();
  endtask
  task automatic test_sleep_entry();
    bus.wfi_req = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      logic [2:0] st;
      logic       w, en;
      tick();
      st = (e <= 4) ? 3'd1 : (e == 5) ? 3'd2 : 3'd3;
      w  = e >= 5;
      en = e != 6;
      checks++;
      if ({bus.state, bus.wfi, bus.core_clk_en, bus.wfi_ack} !== {st, w, en, 1'b0}) begin
        errors++;
        $display("FAIL sleep_entry edge %0d: got st=%0d wfi=%b en=%b ack=%b want st=%0d wfi=%b en=%b ack=0",
                 e, bus.state, bus.wfi, bus.core_clk_en, bus.wfi_ack, st, w, en);
      end
    end
  endtask
  task automatic test_wake();
    repeat (3) tick();
    bus.irq_pending = 1'b1;
    tick();
    bus.irq_pending = 1'b0;
    checks++;
    if ({bus.state, bus.wfi, bus.core_clk_en} !== {3'd4, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL wake k+1: got st=%0d wfi=%b en=%b want 4 1 1", bus.state, bus.wfi, bus.core_clk_en);
    end
    for (int e = 2; e <= 8; e++) begin
      tick();
      checks++;
      if ({bus.state, bus.wfi, bus.wfi_ack} !== {3'd4, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL wake k+%0d: got st=%0d wfi=%b ack=%b want 4 1 0", e, bus.state, bus.wfi, bus.wfi_ack);
      end
    end
    tick();
    checks++;
    if ({bus.state, bus.wfi, bus.core_clk_en, bus.wfi_ack} !== {3'd0, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL wake k+9: got st=%0d wfi=%b en=%b ack=%b want 0 0 1 1",
               bus.state, bus.wfi, bus.core_clk_en, bus.wfi_ack);
    end
    bus.wfi_req = 1'b0;
    tick();
    checks++;
    if ({bus.state, bus.wfi_ack} !== {3'd0, 1'b0}) begin
      errors++;
      $display("FAIL wake k+10: got st=%0d ack=%b want 0 0", bus.state, bus.wfi_ack);
    end
  endtask
  task automatic test_led_wr();
    bus.wfi_req = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      bus.led_wr = (e == 3 || e == 6);
      tick();
      checks++;
      if ({bus.state, bus.wfi} !== ((e < 10) ? {3'd1, 1'b0} : {3'd2, 1'b1})) begin
        errors++;
        $display("FAIL led_wr edge %0d: got st=%0d wfi=%b want st=%0d wfi=%b",
                 e, bus.state, bus.wfi, (e < 10) ? 1 : 2, e >= 10);
      end
    end
    bus.led_wr = 1'b0;
    tick();
    wake_up("led_wr");
  endtask
  task automatic test_abort();
    bus.wfi_req = 1'b1;
    bus.irq_pending = 1'b1;
    tick();
    checks++;
    if ({bus.state, bus.wfi, bus.core_clk_en, bus.wfi_ack} !== {3'd0, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL abort_run: got st=%0d wfi=%b en=%b ack=%b want 0 0 1 1",
               bus.state, bus.wfi, bus.core_clk_en, bus.wfi_ack);
    end
    bus.wfi_req = 1'b0;
    bus.irq_pending = 1'b0;
    tick();
    checks++;
    if (bus.wfi_ack !== 1'b0) begin
      errors++;
      $display("FAIL abort_run pulse width: got ack=%b want 0", bus.wfi_ack);
    end
    bus.wfi_req = 1'b1;
    tick();
    tick();
    bus.irq_pending = 1'b1;
    tick();
    checks++;
    if ({bus.state, bus.wfi, bus.wfi_ack} !== {3'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL abort_drain: got st=%0d wfi=%b ack=%b want 0 0 1", bus.state, bus.wfi, bus.wfi_ack);
    end
    bus.wfi_req = 1'b0;
    bus.irq_pending = 1'b0;
    tick();
    bus.wfi_req = 1'b1;
    tick();
    tick();
    bus.wfi_req = 1'b0;
    tick();
    checks++;
    if ({bus.state, bus.wfi_ack} !== {3'd0, 1'b0}) begin
      errors++;
      $display("FAIL spurious_drop: got st=%0d ack=%b want 0 0", bus.state, bus.wfi_ack);
    end
  endtask
  task automatic test_gate_irq();
    bus.wfi_req = 1'b1;
    repeat (5) tick();
    bus.irq_pending = 1'b1;
    tick();
    checks++;
    if ({bus.state, bus.wfi, bus.core_clk_en} !== {3'd4, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL gate_irq: got st=%0d wfi=%b en=%b want 4 1 1", bus.state, bus.wfi, bus.core_clk_en);
    end
    bus.irq_pending = 1'b0;
    repeat (7) tick();
    tick();
    checks++;
    if ({bus.state, bus.wfi_ack} !== {3'd0, 1'b1}) begin
      errors++;
      $display("FAIL gate_irq ack: got st=%0d ack=%b want 0 1", bus.state, bus.wfi_ack);
    end
    bus.wfi_req = 1'b0;
    tick();
  endtask
  task automatic test_async_reset();
    enter_sleep();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.state, bus.wfi, bus.core_clk_en, bus.wfi_ack} !== {3'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got st=%0d wfi=%b en=%b ack=%b want 0 0 1 0",
               bus.state, bus.wfi, bus.core_clk_en, bus.wfi_ack);
    end
    bus.wfi_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask
  task automatic test_timeout();
    enter_sleep();
`ifdef WFI_SEQ_TIMEOUT_EN
    for (int e = 1; e <= 17; e++) begin
      tick();
      checks++;
      if ({bus.state, bus.timeout_wake} !== ((e < 16) ? {3'd3, 1'b0} : (e == 16) ? {3'd4, 1'b1} : {3'd4, 1'b0})) begin
        errors++;
        $display("FAIL timeout edge %0d: got st=%0d tw=%b", e, bus.state, bus.timeout_wake);
      end
    end
    for (int i = 0; i < 20 && bus.wfi_ack !== 1'b1; i++) tick();
    bus.wfi_req = 1'b0;
    tick();
    enter_sleep();
    repeat (15) tick();
    bus.irq_pending = 1'b1;
    tick();
    checks++;
    if ({bus.state, bus.timeout_wake} !== {3'd4, 1'b0}) begin
      errors++;
      $display("FAIL timeout_irq_wins: got st=%0d tw=%b want 4 0", bus.state, bus.timeout_wake);
    end
    bus.irq_pending = 1'b0;
    for (int i = 0; i < 20 && bus.wfi_ack !== 1'b1; i++) tick();
    bus.wfi_req = 1'b0;
    tick();
`else
    for (int e = 1; e <= 20; e++) begin
      tick();
      checks++;
      if ({bus.state, bus.timeout_wake} !== {3'd3, 1'b0}) begin
        errors++;
        $display("FAIL no_timeout edge %0d: got st=%0d tw=%b want 3 0", e, bus.state, bus.timeout_wake);
      end
    end
    wake_up("no_timeout");
`endif
  endtask
  initial begin
    test_reset();
    test_sleep_entry();
    test_wake();
    test_led_wr();
    test_abort();
    test_gate_irq();
    test_async_reset();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wfi_sleep_seq.md
# wfi_sleep_seq

Sleep-entry/exit sequencer for the iCEGate low-power path. Runs on the always-on 12 MHz HFOSC clock. On a CPU WFI request it lets in-flight LED register writes land, then gates the Bank-2 LED pads through the pad-freeze block's `wfi` input. One cycle later it stops the core clock. On an interrupt it restarts the clock, waits a settle interval, releases the pads and acknowledges the CPU.

## Interface
- `DRAIN_CYCLES`, 4: quiet cycles (no `led_wr`) required before pads are gated; legal 1..255.
- `WAKE_CYCLES`, 8: cycles the core clock runs before pads are released and CPU acked; legal 1..255.
- `TIMEOUT_CYCLES`, 16'hFFFF: sleep watchdog length; used only with `WFI_SEQ_TIMEOUT_EN`; legal 2..65535.
- `clk` in 1: always-on HFOSC clock (never gated).
- `rst_n` in 1: asynchronous, active-low reset.
- `wfi_req` in 1: CPU retired WFI; level; CPU holds it high until `wfi_ack`.
- `irq_pending` in 1: level; any enabled interrupt pending.
- `led_wr` in 1: LED register written this cycle.
- `wfi` out 1: to pad-freeze block; 1 = LED pads output-disabled.
- `core_clk_en` out 1: core clock enable; 0 = core clock gated.
- `wfi_ack` out 1: one-cycle pulse; CPU may resume.
- `timeout_wake` out 1: one-cycle pulse; the wake was caused by the watchdog.
- `state` out 3: current state encoding, for debug.

## Operation
- States and encodings: RUN=0, DRAIN=1, GATE=2, SLEEP=3, WAKE=4. Encodings 5–7 are illegal and recover to RUN on the next edge.
- All outputs are registered.
- Reset values: state=RUN, `wfi`=0, `core_clk_en`=1, `wfi_ack`=0, `timeout_wake`=0, counters=0.
- Counter `cnt` is 8 bits and loads N-1 for an N-cycle interval.
- **RUN**
  - `wfi_req`=1 and `irq_pending`=0: go to DRAIN, `cnt`=DRAIN_CYCLES-1.
  - `wfi_req`=1 and `irq_pending`=1: stay in RUN and pulse `wfi_ack` next cycle (WFI aborted).
- **DRAIN**
  - `led_wr`=1 reloads `cnt`=DRAIN_CYCLES-1.
  - `irq_pending`=1: go to RUN and pulse `wfi_ack`.
  - `wfi_req`=0 (spurious drop): go to RUN, no ack.
  - `cnt`==0 and `led_wr`=0: go to GATE.
  - Priority: `irq_pending` > `wfi_req` drop > `led_wr` > count.
- **GATE** (exactly one cycle)
  - `wfi`=1, `core_clk_en`=1.
  - Next state is SLEEP, or WAKE if `irq_pending`=1.
- **SLEEP**
  - `wfi`=1, `core_clk_en`=0.
  - `irq_pending`=1: go to WAKE, `cnt`=WAKE_CYCLES-1, `core_clk_en`=1 on the same edge.
- **WAKE**
  - `core_clk_en`=1, `wfi`=1.
  - At `cnt`==0: go to RUN; `wfi`=0 and `wfi_ack`=1 on the same edge.
  - The wake is committed: `irq_pending` deasserting in WAKE is ignored, and a new `wfi_req` is not sampled until RUN.
- Ordering invariants (assertable):
  - `core_clk_en` falls only while `wfi`=1.
  - `wfi` falls only while `core_clk_en`=1.
  - `wfi_ack` never fires while `wfi`=1 after the edge.
- Reset asserted mid-sequence forces the reset values immediately (asynchronous): pads are un-gated and the clock enabled with no ack.

## Timing
- Sleep entry, with `wfi_req` sampled at edge 0, no `led_wr`, no irq:
  - DRAIN from edge 1.
  - GATE at edge 1+DRAIN_CYCLES; `wfi`=1 from that edge.
  - SLEEP at edge 2+DRAIN_CYCLES; `core_clk_en`=0.
- Wake, with `irq_pending` sampled in SLEEP at edge k:
  - `core_clk_en`=1 from edge k+1.
  - `wfi`=0 and `wfi_ack`=1 at edge k+1+WAKE_CYCLES.
- Abort latency: `wfi_ack` one edge after `irq_pending` is sampled in RUN or DRAIN.
- `wfi_ack` and `timeout_wake` are high for exactly one cycle.

## Configuration
- `WFI_SEQ_TIMEOUT_EN` defined:
  - A 16-bit sleep counter clears on SLEEP entry and increments each SLEEP cycle.
  - At count TIMEOUT_CYCLES-1 with `irq_pending`=0, go to WAKE and pulse `timeout_wake` on that edge.
  - Irq and timeout in the same cycle: the irq wins, `timeout_wake`=0.
- Undefined: no sleep counter; SLEEP exits only on irq; `timeout_wake` is tied to 0.

## Test plan
- Reset then `wfi_req`=1, DRAIN_CYCLES=4, no irq -> `wfi`=1 at edge 5, `core_clk_en`=0 at edge 6, `state`=3.
- `led_wr` pulses at DRAIN cycles 2 and 5 -> GATE entry delayed to 4 quiet cycles after the last pulse; `wfi` stays 0 until then.
- `irq_pending` raised at SLEEP edge k, WAKE_CYCLES=8 -> `core_clk_en`=1 at k+1; `wfi`=0 and `wfi_ack`=1 at k+9; `wfi_ack`=0 at k+10.
- `wfi_req` and `irq_pending` both high in RUN -> `wfi_ack` at the next edge; `wfi` and `core_clk_en` never change.
- `rst_n` dropped while in SLEEP -> `wfi`=0, `core_clk_en`=1, `state`=0 without waiting for a clock edge; no `wfi_ack`.
- With `WFI_SEQ_TIMEOUT_EN` and TIMEOUT_CYCLES=16, no irq -> WAKE after 16 SLEEP cycles with `timeout_wake`=1 for one cycle; irq on cycle 16 -> `timeout_wake`=0.
